// File: rtl/kamus_pkg.sv
// Shared types for the kamus-v pipeline control unit: instruction classes,
// the per-stage control word and the bubble constants.
package kamus_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic [3:0] {
    IT_LUI   = 4'd0,
    IT_AUIPC = 4'd1,
    IT_ALU   = 4'd2,
    IT_ALU_I = 4'd3,
    IT_JAL   = 4'd4,
    IT_JALR  = 4'd5,
    IT_B     = 4'd6,
    IT_L     = 4'd7,
    IT_S     = 4'd8
  } instr_type_t;

  typedef enum logic [1:0] {
    PC_ST = 2'd0,
    J_ST  = 2'd1,
    B_ST  = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'd0,
    NEXT_PC    = 2'd1,
    MEM_DATA   = 2'd2
  } wb_sel_t;

  typedef struct packed {
    pc_sel_t              pc_sel;
    wb_sel_t              wb_sel;
    logic                 regfile_wr_en;
    logic                 l1d_wr_en;
    logic [RF_ADDR_W-1:0] rd;
  } control_unit_t;

  typedef struct packed {
    logic          valid;
    control_unit_t ctrl;
  } stage_ctrl_t;

  localparam control_unit_t CTRL_NOP = '{
    pc_sel:        PC_ST,
    wb_sel:        ALU_RESULT,
    regfile_wr_en: 1'b0,
    l1d_wr_en:     1'b0,
    rd:            '0
  };

  localparam stage_ctrl_t STAGE_BUBBLE = '{valid: 1'b0, ctrl: CTRL_NOP};

  // x0 is hardwired, so a stage targeting it never produces a value.
  function automatic logic is_writer(stage_ctrl_t s);
    return s.valid && s.ctrl.regfile_wr_en && (s.ctrl.rd != '0);
  endfunction

endpackage

// File: rtl/kamus_pipe_ctrl_if.sv
// Decode/datapath-facing signal bundle of the pipeline control unit.
// master = decoder/datapath side, slave = kamus_pipe_ctrl.
interface kamus_pipe_ctrl_if
  import kamus_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = RF_ADDR_W
);

  logic                  dec_valid_i;
  instr_type_t           dec_instr_type_i;
  logic [REG_ADDR_W-1:0] dec_rd_i;
  logic [REG_ADDR_W-1:0] dec_rs1_i;
  logic [REG_ADDR_W-1:0] dec_rs2_i;
  logic                  dec_use_rs1_i;
  logic                  dec_use_rs2_i;
  logic                  ex_branch_taken_i;
  logic                  mem_busy_i;
  logic                  stall_o;
  logic                  flush_o;
  logic [NUM_STAGES-1:0] stage_valid_o;
  control_unit_t         stage_ctrl_o [NUM_STAGES];

  modport master (
    output dec_valid_i, dec_instr_type_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
           dec_use_rs1_i, dec_use_rs2_i, ex_branch_taken_i, mem_busy_i,
    input  stall_o, flush_o, stage_valid_o, stage_ctrl_o
  );

  modport slave (
    input  dec_valid_i, dec_instr_type_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
           dec_use_rs1_i, dec_use_rs2_i, ex_branch_taken_i, mem_busy_i,
    output stall_o, flush_o, stage_valid_o, stage_ctrl_o
  );

endinterface

// File: rtl/kamus_ctrl_decode.sv
// Combinational decode of the instruction class into a control word.
// Non-writing instructions carry rd = 0 so downstream hazard checks ignore them.
module kamus_ctrl_decode
  import kamus_pkg::*;
(
  input  logic                 valid,
  input  instr_type_t          instr_type,
  input  logic [RF_ADDR_W-1:0] rd,
  output control_unit_t        ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    if (valid) begin
      case (instr_type)
        IT_LUI, IT_AUIPC, IT_ALU, IT_ALU_I: begin
          ctrl.wb_sel        = ALU_RESULT;
          ctrl.regfile_wr_en = 1'b1;
        end
        IT_JAL, IT_JALR: begin
          ctrl.pc_sel        = J_ST;
          ctrl.wb_sel        = NEXT_PC;
          ctrl.regfile_wr_en = 1'b1;
        end
        IT_B:    ctrl.pc_sel = B_ST;
        IT_L: begin
          ctrl.wb_sel        = MEM_DATA;
          ctrl.regfile_wr_en = 1'b1;
        end
        IT_S:    ctrl.l1d_wr_en = 1'b1;
        default: ctrl = CTRL_NOP;
      endcase
      if (ctrl.regfile_wr_en) ctrl.rd = rd;
    end
  end

endmodule

// File: rtl/kamus_pipe_ctrl.sv
// Pipelined control unit: carries decoded control words through the
// post-decode stages and resolves RAW stall, branch/jump flush and L1D freeze.
module kamus_pipe_ctrl
  import kamus_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int MEM_STAGE  = 1,
  parameter int FWD_EN     = 1,
  parameter int REG_ADDR_W = RF_ADDR_W
) (
  input logic              clk_i,
  input logic              rst_i,
  kamus_pipe_ctrl_if.slave bus
);

  if (NUM_STAGES < 3 || NUM_STAGES > 6 || MEM_STAGE < 1 || MEM_STAGE > NUM_STAGES - 2
      || REG_ADDR_W != RF_ADDR_W) begin : g_bad_cfg
    $error("kamus_pipe_ctrl: unsupported parameter combination");
  end

  control_unit_t dec_ctrl;
  stage_ctrl_t   stage_q [NUM_STAGES];
  stage_ctrl_t   stage_d [NUM_STAGES];
  logic          hazard;
  logic          flush;

  kamus_ctrl_decode u_decode (
    .valid      (bus.dec_valid_i),
    .instr_type (bus.dec_instr_type_i),
    .rd         (bus.dec_rd_i),
    .ctrl       (dec_ctrl)
  );

  // With forwarding only a load in EX is too late; without it every
  // in-flight writer must retire before the regfile read is safe.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (is_writer(stage_q[k])
          && (FWD_EN == 0 || (k == 0 && stage_q[k].ctrl.wb_sel == MEM_DATA))
          && ((bus.dec_use_rs1_i && bus.dec_rs1_i == stage_q[k].ctrl.rd)
              || (bus.dec_use_rs2_i && bus.dec_rs2_i == stage_q[k].ctrl.rd)))
        hazard = 1'b1;
    end
    hazard = hazard && bus.dec_valid_i;
  end

  assign flush = stage_q[0].valid
               && (stage_q[0].ctrl.pc_sel == J_ST
                   || (stage_q[0].ctrl.pc_sel == B_ST && bus.ex_branch_taken_i))
               && !bus.mem_busy_i;

  assign bus.flush_o = flush;
  assign bus.stall_o = bus.mem_busy_i || (hazard && !flush);

  always_comb begin
    stage_d[0] = (hazard || flush) ? STAGE_BUBBLE : {bus.dec_valid_i, dec_ctrl};
    for (int k = 1; k < NUM_STAGES; k++) stage_d[k] = stage_q[k-1];
    // Freeze: everything up to MEM waits on L1D, the stage after it drains.
    if (bus.mem_busy_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (k <= MEM_STAGE)          stage_d[k] = stage_q[k];
        else if (k == MEM_STAGE + 1) stage_d[k] = STAGE_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign bus.stage_valid_o[k] = stage_q[k].valid;
    assign bus.stage_ctrl_o[k]  = stage_q[k].ctrl;
  end

endmodule

// File: tb/tb_kamus_pipe_ctrl.sv
// Bench for kamus_pipe_ctrl: three configurations share one stimulus stream and
// are compared every cycle against an instruction-level pipeline model.
module tb_kamus_pipe_ctrl;
  import kamus_pkg::*;

  typedef struct {
    logic        v;
    instr_type_t t;
    logic [4:0]  rd;
  } mstage_t;

  int ns_c   [3] = '{3, 3, 5};
  int mem_c  [3] = '{1, 1, 2};
  int fwd_c  [3] = '{1, 0, 1};

  logic        clk, rst;
  logic        dec_valid, use1, use2, taken, busy;
  instr_type_t dec_type;
  logic [4:0]  dec_rd, rs1, rs2;

  logic          ov [3][6];
  control_unit_t oc [3][6];
  logic          os [3];
  logic          of [3];

  mstage_t m [3][6];
  mstage_t n [3][6];
  logic    last_stall [3];
  logic    last_flush [3];
  logic    dut_stall  [3];
  logic    dut_flush  [3];
  int      cnt_stall  [3];
  int      cnt_flush  [3];
  int      total, bad;

  kamus_pipe_ctrl_if #(.NUM_STAGES(3)) bus_a ();
  kamus_pipe_ctrl_if #(.NUM_STAGES(3)) bus_b ();
  kamus_pipe_ctrl_if #(.NUM_STAGES(5)) bus_c ();

  kamus_pipe_ctrl #(.NUM_STAGES(3), .MEM_STAGE(1), .FWD_EN(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  kamus_pipe_ctrl #(.NUM_STAGES(3), .MEM_STAGE(1), .FWD_EN(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
  kamus_pipe_ctrl #(.NUM_STAGES(5), .MEM_STAGE(2), .FWD_EN(1)) dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

  assign bus_a.dec_valid_i = dec_valid;  assign bus_b.dec_valid_i = dec_valid;  assign bus_c.dec_valid_i = dec_valid;
  assign bus_a.dec_instr_type_i = dec_type; assign bus_b.dec_instr_type_i = dec_type; assign bus_c.dec_instr_type_i = dec_type;
  assign bus_a.dec_rd_i = dec_rd;  assign bus_b.dec_rd_i = dec_rd;  assign bus_c.dec_rd_i = dec_rd;
  assign bus_a.dec_rs1_i = rs1;    assign bus_b.dec_rs1_i = rs1;    assign bus_c.dec_rs1_i = rs1;
  assign bus_a.dec_rs2_i = rs2;    assign bus_b.dec_rs2_i = rs2;    assign bus_c.dec_rs2_i = rs2;
  assign bus_a.dec_use_rs1_i = use1; assign bus_b.dec_use_rs1_i = use1; assign bus_c.dec_use_rs1_i = use1;
  assign bus_a.dec_use_rs2_i = use2; assign bus_b.dec_use_rs2_i = use2; assign bus_c.dec_use_rs2_i = use2;
  assign bus_a.ex_branch_taken_i = taken; assign bus_b.ex_branch_taken_i = taken; assign bus_c.ex_branch_taken_i = taken;
  assign bus_a.mem_busy_i = busy;  assign bus_b.mem_busy_i = busy;  assign bus_c.mem_busy_i = busy;

  assign os[0] = bus_a.stall_o; assign os[1] = bus_b.stall_o; assign os[2] = bus_c.stall_o;
  assign of[0] = bus_a.flush_o; assign of[1] = bus_b.flush_o; assign of[2] = bus_c.flush_o;

  for (genvar k = 0; k < 6; k++) begin : g_obs
    if (k < 3) begin : g_a
      assign ov[0][k] = bus_a.stage_valid_o[k]; assign oc[0][k] = bus_a.stage_ctrl_o[k];
      assign ov[1][k] = bus_b.stage_valid_o[k]; assign oc[1][k] = bus_b.stage_ctrl_o[k];
    end else begin : g_a0
      assign ov[0][k] = 1'b0; assign oc[0][k] = '0;
      assign ov[1][k] = 1'b0; assign oc[1][k] = '0;
    end
    if (k < 5) begin : g_c
      assign ov[2][k] = bus_c.stage_valid_o[k]; assign oc[2][k] = bus_c.stage_ctrl_o[k];
    end else begin : g_c0
      assign ov[2][k] = 1'b0; assign oc[2][k] = '0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic wr_type(instr_type_t t);
    return t inside {IT_LUI, IT_AUIPC, IT_ALU, IT_ALU_I, IT_JAL, IT_JALR, IT_L};
  endfunction

  function automatic control_unit_t nop_w();
    control_unit_t w;
    w.pc_sel = PC_ST; w.wb_sel = ALU_RESULT;
    w.regfile_wr_en = 1'b0; w.l1d_wr_en = 1'b0; w.rd = 5'd0;
    return w;
  endfunction

  // Expected control word straight from the decode table.
  function automatic control_unit_t exp_w(instr_type_t t, logic [4:0] rd);
    control_unit_t w;
    logic is_j;
    is_j = (t == IT_JAL) || (t == IT_JALR);
    w = nop_w();
    w.pc_sel = is_j ? J_ST : (t == IT_B) ? B_ST : PC_ST;
    w.wb_sel = is_j ? NEXT_PC : (t == IT_L) ? MEM_DATA : ALU_RESULT;
    w.regfile_wr_en = wr_type(t);
    w.l1d_wr_en = (t == IT_S);
    w.rd = wr_type(t) ? rd : 5'd0;
    return w;
  endfunction

  function automatic logic m_hz(int i);
    logic h;
    h = 1'b0;
    for (int k = 0; k < ns_c[i]; k++) begin
      if (m[i][k].v && wr_type(m[i][k].t) && m[i][k].rd != 5'd0
          && (fwd_c[i] == 0 || (k == 0 && m[i][k].t == IT_L))
          && ((use1 && rs1 == m[i][k].rd) || (use2 && rs2 == m[i][k].rd)))
        h = dec_valid;
    end
    return h;
  endfunction

  function automatic logic m_fl(int i);
    return m[i][0].v && !busy
        && (m[i][0].t == IT_JAL || m[i][0].t == IT_JALR || (m[i][0].t == IT_B && taken));
  endfunction

  task automatic chk(input string tag, input int inst, input int stg,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d stage=%0d observed=%0h expected=%0h", tag, inst, stg, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 6; k++) m[i][k] = '{v: 1'b0, t: IT_LUI, rd: 5'd0};
  endtask

  // Entered at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic cycle();
    logic hz, fl;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      hz = m_hz(i);
      fl = m_fl(i);
      last_stall[i] = busy | (hz & !fl);
      last_flush[i] = fl;
      dut_stall[i]  = os[i];
      dut_flush[i]  = of[i];
      cnt_stall[i] += int'(os[i]);
      cnt_flush[i] += int'(of[i]);
      chk("stall", i, -1, 32'(os[i]), 32'(last_stall[i]));
      chk("flush", i, -1, 32'(of[i]), 32'(fl));
      for (int k = 0; k < ns_c[i]; k++) begin
        chk("valid", i, k, 32'(ov[i][k]), 32'(m[i][k].v));
        chk("ctrl", i, k, 32'(oc[i][k]), 32'(m[i][k].v ? exp_w(m[i][k].t, m[i][k].rd) : nop_w()));
      end
      for (int k = 0; k < 6; k++) n[i][k] = m[i][k];
      if (busy) begin
        for (int k = ns_c[i] - 1; k > mem_c[i] + 1; k--) n[i][k] = m[i][k-1];
        n[i][mem_c[i] + 1] = '{v: 1'b0, t: IT_LUI, rd: 5'd0};
      end else begin
        for (int k = ns_c[i] - 1; k > 0; k--) n[i][k] = m[i][k-1];
        if (hz || fl || !dec_valid) n[i][0] = '{v: 1'b0, t: IT_LUI, rd: 5'd0};
        else                        n[i][0] = '{v: 1'b1, t: dec_type, rd: dec_rd};
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 6; k++) m[i][k] = n[i][k];
  endtask

  task automatic idle(input int cycles);
    dec_valid = 1'b0;
    repeat (cycles) cycle();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 3; i++) begin cnt_stall[i] = 0; cnt_flush[i] = 0; end
  endtask

  // Presents one instruction and holds it while configuration prim stalls.
  task automatic issue(input instr_type_t t, input logic [4:0] rd_v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u1, input logic u2, input int prim);
    logic done;
    dec_valid = 1'b1; dec_type = t; dec_rd = rd_v; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cycle();
      if (!last_stall[prim]) done = 1'b1;
    end
    chk("issue_accepted", prim, -1, 32'(done), 32'd1);
    dec_valid = 1'b0; use1 = 1'b0; use2 = 1'b0;
  endtask

  task automatic reset_check();
    rst = 1'b1; dec_valid = 1'b0; busy = 1'b0; taken = 1'b0; use1 = 1'b0; use2 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_stall", i, -1, 32'(os[i]), 32'd0);
      chk("rst_flush", i, -1, 32'(of[i]), 32'd0);
      for (int k = 0; k < ns_c[i]; k++) begin
        chk("rst_valid", i, k, 32'(ov[i][k]), 32'd0);
        chk("rst_ctrl", i, k, 32'(oc[i][k]), 32'(nop_w()));
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; dec_valid = 1'b0; dec_type = IT_LUI; dec_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    use1 = 1'b0; use2 = 1'b0; taken = 1'b0; busy = 1'b0;
    model_reset();
    clr_cnt();
    #1;
    reset_check();
    idle(2);

    // Decode table, including an out-of-range type.
    issue(IT_LUI,   5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_AUIPC, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_ALU,   5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_ALU_I, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_L,     5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_S,     5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_B,     5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_JAL,   5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_JALR,  5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(instr_type_t'(4'd13), 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    idle(7);

    // Load-use with forwarding: exactly one bubble.
    issue(IT_L, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    clr_cnt();
    issue(IT_ALU, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 0);
    chk("loaduse_stall_len", 0, -1, 32'(cnt_stall[0]), 32'd1);
    idle(7);

    // RAW without forwarding: stall until the producer leaves WB.
    issue(IT_ALU_I, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    clr_cnt();
    issue(IT_ALU, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1);
    chk("raw_stall_len", 1, -1, 32'(cnt_stall[1]), 32'd3);
    idle(7);
    issue(IT_ALU_I, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    clr_cnt();
    issue(IT_ALU, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1);
    chk("raw_x0_stall_len", 1, -1, 32'(cnt_stall[1]), 32'd0);
    idle(7);

    // Taken and not-taken branch.
    issue(IT_B, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 0);
    taken = 1'b1;
    clr_cnt();
    issue(IT_ALU, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    taken = 1'b0;
    idle(2);
    chk("taken_flush_len", 0, -1, 32'(cnt_flush[0]), 32'd1);
    idle(5);
    issue(IT_B, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 0);
    clr_cnt();
    issue(IT_ALU, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    idle(2);
    chk("nottaken_flush_len", 0, -1, 32'(cnt_flush[0]), 32'd0);
    idle(5);

    // Jump in EX beats a RAW hazard on its own rd.
    issue(IT_JAL, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    issue(IT_ALU, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1);
    chk("jal_hz_flush", 1, -1, 32'(dut_flush[1]), 32'd1);
    chk("jal_hz_stall", 1, -1, 32'(dut_stall[1]), 32'd0);
    idle(7);

    // Store in MEM with a 4-cycle L1D wait and a jump waiting in EX.
    issue(IT_S, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 0);
    issue(IT_JAL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    dec_valid = 1'b1; dec_type = IT_ALU; dec_rd = 5'd2;
    busy = 1'b1;
    clr_cnt();
    repeat (4) cycle();
    chk("freeze_stall_len", 0, -1, 32'(cnt_stall[0]), 32'd4);
    chk("freeze_no_flush", 0, -1, 32'(cnt_flush[0]), 32'd0);
    busy = 1'b0;
    cycle();
    chk("post_freeze_flush", 0, -1, 32'(dut_flush[0]), 32'd1);
    idle(7);

    // Reset in the middle of a hazard stall and of a freeze.
    issue(IT_ALU_I, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    dec_valid = 1'b1; dec_type = IT_ALU; dec_rd = 5'd4; rs1 = 5'd3; use1 = 1'b1;
    cycle();
    reset_check();
    issue(IT_L, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    issue(IT_S, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 0);
    busy = 1'b1;
    repeat (2) cycle();
    reset_check();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      dec_valid = 1'($urandom_range(0, 3) != 0);
      dec_type  = instr_type_t'(4'($urandom_range(0, 15)));
      dec_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      use1      = 1'($urandom_range(0, 1));
      use2      = 1'($urandom_range(0, 1));
      taken     = 1'($urandom_range(0, 1));
      busy      = 1'($urandom_range(0, 3) == 0);
      cycle();
    end
    busy = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
